// File: rtl/bus_sram_rsp.sv
// Word-organised SRAM responder for the core's valid/ready bus with lane steering,
// programmable wait states and illegal-access flagging. Optional write protection: SRAM_RSP_WP_EN.
module bus_sram_rsp #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              valid,
    input  logic              write,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic [31:0]       wdata,
`ifdef SRAM_RSP_WP_EN
    input  logic [ADDR_W-1:0] wp_limit,
`endif
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);
    // Handshake: a request is taken on the first edge in IDLE with valid=1; the
    // initiator holds valid until it sees the single-cycle ready pulse. Dropping
    // valid during WAITS aborts the request with no ready and no write.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAITS = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;

    logic [31:0] mem [DEPTH];

    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [1:0]        cur_size;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-3:0] cur_idx;
    logic              illegal;
    logic              wp_hit;
    logic              enter_resp;
    logic              do_write;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_val;

    // With WAIT=0 the access happens on the capture edge, so the live inputs are used.
    assign cur_write = (state == IDLE) ? write : req_write;
    assign cur_addr  = (state == IDLE) ? addr  : req_addr;
    assign cur_size  = (state == IDLE) ? size  : req_size;
    assign cur_wdata = (state == IDLE) ? wdata : req_wdata;
    assign cur_idx   = cur_addr[ADDR_W-1:2];

    assign illegal = (cur_size == 2'b11)
                   || ((cur_size == 2'b01) && cur_addr[0])
                   || ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00))
                   || (cur_addr[31:ADDR_W] != '0);

`ifdef SRAM_RSP_WP_EN
    logic [ADDR_W-1:0] req_wp;
    logic [ADDR_W-1:0] cur_wp;
    assign cur_wp = (state == IDLE) ? wp_limit : req_wp;
    assign wp_hit = cur_write && !illegal && (cur_addr[ADDR_W-1:0] < cur_wp);
`else
    assign wp_hit = 1'b0;
`endif

    assign enter_resp = rstb && valid
                      && (((state == IDLE) && (WAIT == 0))
                       || ((state == WAITS) && (cnt == 4'd0)));
    assign do_write = enter_resp && cur_write && !illegal && !wp_hit;

    always_comb begin
        wr_be = 4'b0000;
        case (cur_size)
            2'b00:   wr_be = 4'b0001 << cur_addr[1:0];
            2'b01:   wr_be = 4'b0011 << cur_addr[1:0];
            default: wr_be = 4'b1111 << cur_addr[1:0];
        endcase
    end

    assign wr_data  = cur_wdata << {cur_addr[1:0], 3'b000};
    assign rd_shift = mem[cur_idx] >> {cur_addr[1:0], 3'b000};

    always_comb begin
        rd_val = rd_shift;
        case (cur_size)
            2'b00:   rd_val = {24'h0, rd_shift[7:0]};
            2'b01:   rd_val = {16'h0, rd_shift[15:0]};
            default: rd_val = rd_shift;
        endcase
    end

    // SRAM array: no reset, only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[cur_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_write <= 1'b0;
            req_addr  <= 32'h0;
            req_size  <= 2'b00;
            req_wdata <= 32'h0;
            err       <= 1'b0;
            rdata     <= 32'h0;
`ifdef SRAM_RSP_WP_EN
            req_wp    <= '0;
`endif
        end else begin
            err <= enter_resp && (illegal || wp_hit);
            if (enter_resp) begin
                if (illegal)         rdata <= 32'h0;
                else if (!cur_write) rdata <= rd_val;
            end
            case (state)
                IDLE: begin
                    if (valid) begin
                        req_write <= write;
                        req_addr  <= addr;
                        req_size  <= size;
                        req_wdata <= wdata;
`ifdef SRAM_RSP_WP_EN
                        req_wp    <= wp_limit;
`endif
                        cnt       <= WAIT_LOAD;
                        state     <= (WAIT == 0) ? RESP : WAITS;
                    end
                end
                WAITS: begin
                    if (!valid)            state <= IDLE;
                    else if (cnt == 4'd0)  state <= RESP;
                    else                   cnt   <= cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == RESP);
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_sram_rsp.sv
// Directed bench for bus_sram_rsp: one WAIT=0 and one WAIT=3 instance share the
// request bus; a reference model fills an expected queue popped at each ready pulse.
module tb_bus_sram_rsp;
    logic        clk = 1'b0;
    logic        rstb;
    logic        valid0, valid3;
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        ready0, ready3, err0, err3;
    logic [31:0] rdata0, rdata3;
    logic [1:0]  state0, state3;
`ifdef SRAM_RSP_WP_EN
    logic [11:0] wp_limit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mdl [2][1024];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    bus_sram_rsp #(.ADDR_W(12), .WAIT(0)) u_dut0 (
        .clk(clk), .rstb(rstb), .valid(valid0), .write(write), .addr(addr),
        .size(size), .wdata(wdata),
`ifdef SRAM_RSP_WP_EN
        .wp_limit(wp_limit),
`endif
        .ready(ready0), .rdata(rdata0), .err(err0), .dbg_state(state0)
    );

    bus_sram_rsp #(.ADDR_W(12), .WAIT(3)) u_dut3 (
        .clk(clk), .rstb(rstb), .valid(valid3), .write(write), .addr(addr),
        .size(size), .wdata(wdata),
`ifdef SRAM_RSP_WP_EN
        .wp_limit(wp_limit),
`endif
        .ready(ready3), .rdata(rdata3), .err(err3), .dbg_state(state3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {err, rdata} expected for the access and updates memory.
    task automatic model(input int which, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic [31:0] d, output logic [32:0] exp);
        int idx, off, nb;
        bit ill, wp;
        logic [31:0] rd;
        idx = int'(a[11:2]);
        off = int'(a[1:0]);
        nb  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        ill = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
            || (a[31:12] != 20'h0);
        wp  = 1'b0;
`ifdef SRAM_RSP_WP_EN
        wp  = w && !ill && (a[11:0] < wp_limit);
`endif
        if (ill) begin
            last_rd[which] = 32'h0;
            exp = {1'b1, 32'h0};
        end else if (w) begin
            if (!wp) begin
                for (int k = 0; k < nb; k++) mdl[which][idx][8*(off+k) +: 8] = d[8*k +: 8];
            end
            exp = {wp, last_rd[which]};
        end else begin
            rd = 32'h0;
            for (int k = 0; k < nb; k++) rd[8*k +: 8] = mdl[which][idx][8*(off+k) +: 8];
            last_rd[which] = rd;
            exp = {1'b0, rd};
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after ready.
    task automatic xact(input string tag, input int which, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d, input bit keep);
        logic [32:0] exp, got;
        int cyc;
        bit seen;
        model(which, w, a, s, d, exp);
        exp_q.push_back(exp);
        write = w; addr = a; size = s; wdata = d;
        if (which == 0) valid0 = 1'b1; else valid3 = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = (which == 0) ? ready0 : ready3;
        end
        check({tag, "/ready_seen"}, 64'(seen), 64'd1);
        exp = exp_q.pop_front();
        if (seen) begin
            got = (which == 0) ? {err0, rdata0} : {err3, rdata3};
            check({tag, "/latency"}, 64'(cyc), (which == 0) ? 64'd1 : 64'd4);
            check({tag, "/rdata"}, 64'(got[31:0]), 64'(exp[31:0]));
            check({tag, "/err"}, 64'(got[32]), 64'(exp[32]));
        end
        if (!keep) begin
            valid0 = 1'b0;
            valid3 = 1'b0;
        end
        @(negedge clk);
        check({tag, "/ready_pulse"}, 64'((which == 0) ? ready0 : ready3), 64'd0);
        check({tag, "/err_pulse"}, 64'((which == 0) ? err0 : err3), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rstb = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
        write = 1'b0; addr = 32'h0; size = 2'b10; wdata = 32'h0;
`ifdef SRAM_RSP_WP_EN
        wp_limit = 12'h000;
`endif
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset/ready0", 64'(ready0), 64'd0);
        check("reset/err0", 64'(err0), 64'd0);
        check("reset/rdata0", 64'(rdata0), 64'd0);
        check("reset/state3", 64'(state3), 64'd0);
        check("reset/rdata3", 64'(rdata3), 64'd0);
        rstb = 1'b1;
        @(negedge clk);

        xact("word_w0", 0, 1'b1, 32'h010, 2'b10, 32'hDEADBEEF, 1'b0);
        xact("word_r0", 0, 1'b0, 32'h010, 2'b10, 32'h0, 1'b0);
        xact("word_w3", 1, 1'b1, 32'h010, 2'b10, 32'hDEADBEEF, 1'b0);
        xact("word_r3", 1, 1'b0, 32'h010, 2'b10, 32'h0, 1'b0);

        xact("lane_sw", 0, 1'b1, 32'h020, 2'b10, 32'h11223344, 1'b0);
        xact("lane_sb", 0, 1'b1, 32'h022, 2'b00, 32'hFFFFFFAA, 1'b0);
        xact("lane_lw", 0, 1'b0, 32'h020, 2'b10, 32'h0, 1'b0);
        xact("lane_lb", 0, 1'b0, 32'h023, 2'b00, 32'h0, 1'b0);
        xact("lane_lh", 0, 1'b0, 32'h022, 2'b01, 32'h0, 1'b0);

        xact("ill_init", 0, 1'b1, 32'h000, 2'b10, 32'h55667788, 1'b0);
        xact("ill_lw21", 0, 1'b0, 32'h021, 2'b10, 32'h0, 1'b0);
        xact("ill_sw21", 0, 1'b1, 32'h021, 2'b10, 32'hFFFFFFFF, 1'b0);
        xact("ill_sh13", 0, 1'b1, 32'h013, 2'b01, 32'h0000BBBB, 1'b0);
        xact("ill_sz11", 0, 1'b1, 32'h010, 2'b11, 32'h01234567, 1'b0);
        xact("ill_hi_addr", 0, 1'b1, 32'h1000, 2'b10, 32'hFFFFFFFF, 1'b0);
        xact("ill_chk10", 0, 1'b0, 32'h010, 2'b10, 32'h0, 1'b0);
        xact("ill_hi_rd", 0, 1'b0, 32'h1000, 2'b10, 32'h0, 1'b0);
        xact("ill_chk00", 0, 1'b0, 32'h000, 2'b10, 32'h0, 1'b0);
        xact("ill_chk20", 0, 1'b0, 32'h020, 2'b10, 32'h0, 1'b0);

        // Two reads with valid held through the first response.
        xact("b2b_first", 1, 1'b0, 32'h010, 2'b10, 32'h0, 1'b1);
        xact("b2b_second", 1, 1'b0, 32'h010, 2'b01, 32'h0, 1'b0);

        write = 1'b1; addr = 32'h010; size = 2'b10; wdata = 32'h00000099;
        valid3 = 1'b1;
        repeat (2) @(negedge clk);
        valid3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort/no_ready", 64'(ready3), 64'd0);
        end
        xact("abort_chk", 1, 1'b0, 32'h010, 2'b10, 32'h0, 1'b0);

        xact("rst_init", 1, 1'b1, 32'h040, 2'b10, 32'h12345678, 1'b0);
        xact("rst_rd", 1, 1'b0, 32'h040, 2'b10, 32'h0, 1'b0);
        write = 1'b1; addr = 32'h040; size = 2'b10; wdata = 32'hCAFEF00D;
        valid3 = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        #1;
        check("rst_mid/ready", 64'(ready3), 64'd0);
        check("rst_mid/err", 64'(err3), 64'd0);
        check("rst_mid/rdata", 64'(rdata3), 64'd0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        valid3 = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        xact("rst_chk", 1, 1'b0, 32'h040, 2'b10, 32'h0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            xact("rand_w", 0, 1'b1, 32'h200 + 32'(4 * i), 2'b10, v, 1'b0);
            xact("rand_rb", 0, 1'b0, 32'h200 + 32'(4 * i) + 32'($urandom_range(0, 3)), 2'b00, 32'h0, 1'b0);
        end

`ifdef SRAM_RSP_WP_EN
        wp_limit = 12'h000;
        xact("wp_init", 0, 1'b1, 32'h0FC, 2'b10, 32'h00000077, 1'b0);
        wp_limit = 12'h100;
        xact("wp_low", 0, 1'b1, 32'h0FC, 2'b10, 32'h00000005, 1'b0);
        xact("wp_low_rd", 0, 1'b0, 32'h0FC, 2'b10, 32'h0, 1'b0);
        xact("wp_edge", 0, 1'b1, 32'h100, 2'b10, 32'h00000005, 1'b0);
        xact("wp_edge_rd", 0, 1'b0, 32'h100, 2'b10, 32'h0, 1'b0);
`else
        xact("nowp_w", 0, 1'b1, 32'h0FC, 2'b10, 32'h00000005, 1'b0);
        xact("nowp_rd", 0, 1'b0, 32'h0FC, 2'b10, 32'h0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
